// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding and constants for the instruction fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect, instruction-memory and decode handshake signals of the fetch controller
interface fetch_ctrl_if;
  logic        jump;
  logic [31:0] pc_imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_current;
  logic        misalign_err;
  modport master (
    input  jump, pc_imm, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr, instr_valid, pc_current, misalign_err
  );
  modport slave (
    output jump, pc_imm, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr, instr_valid, pc_current, misalign_err
  );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-PC select (hold / +4 / redirect) with redirect alignment; FETCH_MISALIGN_CHECK_EN rejects misaligned targets
module pc_next_calc (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_imm,
  input  logic        i_jump,
  input  logic        i_advance,
  output logic [31:0] o_pc_next,
  output logic        o_jump_ok,
  output logic        o_misalign
);
  logic [31:0] w_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_misalign = i_jump && (i_pc_imm[1:0] != 2'b00);
  assign w_target   = i_pc_imm;
`else
  assign o_misalign = 1'b0;
  assign w_target   = i_pc_imm & 32'hFFFF_FFFC;
`endif
  assign o_jump_ok = i_jump && !o_misalign;
  assign o_pc_next = o_jump_ok ? w_target : i_advance ? i_pc + 32'd4 : i_pc;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: REQ/WAIT/OUT instruction fetch FSM with redirects and stale-response dropping; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect rejection
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);
  state_t      r_state, w_state_next;
  logic [31:0] r_pc, r_instr, w_pc_next;
  logic        r_drop, r_misalign;
  logic        w_jump, w_jump_ok, w_misalign, w_xfer, w_load, w_drop_next;
  assign w_jump = bus.jump && (r_state != S_IDLE);
  assign w_xfer = (r_state == S_OUT) && bus.instr_ready;
  assign w_load = (r_state == S_WAIT) && bus.mem_rvalid && !w_jump_ok && !r_drop;
  // a redirect while waiting leaves a response in flight; it must be swallowed before the next request,
  // unless it arrives in the same cycle as the redirect, in which case it is discarded right there
  assign w_drop_next = ((r_state == S_WAIT) && w_jump_ok && !bus.mem_rvalid) || (r_drop && !bus.mem_rvalid);
  pc_next_calc u_pc_next (
    .i_pc      (r_pc),
    .i_pc_imm  (bus.pc_imm),
    .i_jump    (w_jump),
    .i_advance (w_xfer),
    .o_pc_next (w_pc_next),
    .o_jump_ok (w_jump_ok),
    .o_misalign(w_misalign)
  );
  // next-state selection; an accepted redirect always restarts at REQ
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   w_state_next = (w_jump_ok || r_drop) ? S_REQ : S_WAIT;
      S_WAIT:  w_state_next = w_jump_ok ? S_REQ : bus.mem_rvalid ? S_OUT : S_WAIT;
      default: w_state_next = (w_jump_ok || w_xfer) ? S_REQ : S_OUT;
    endcase
  end
  // state, PC, fetched instruction, drop flag and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_drop     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_load ? bus.mem_rdata : r_instr;
      r_drop     <= w_drop_next;
      r_misalign <= w_misalign;
    end
  end
  assign bus.mem_req      = (r_state == S_REQ) && !r_drop;
  assign bus.mem_addr     = r_pc;
  assign bus.instr        = r_instr;
  assign bus.instr_valid  = (r_state == S_OUT);
  assign bus.pc_current   = r_pc;
  assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench with a memory responder and a per-cycle reference model of the fetch stream
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 0;
  logic reset = 1;
  int n_checks = 0;
  int n_fail = 0;
  int lat = 1;
  int cyc = 0;
  typedef struct {logic [31:0] a; int due;} rsp_t;
  rsp_t q[$];
  logic [31:0] exp_pc = RST_PC;
  bit idle = 1;
  bit exp_mis = 0;
  bit hold = 0;

  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a + 32'h1234_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_sig(input bit want_req, input string name);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = want_req ? bus.mem_req : bus.instr_valid;
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory: record requests mid-cycle, answer exactly lat cycles later
  always @(negedge clk) if (bus.mem_req) q.push_back('{bus.mem_addr, cyc + lat});
  initial begin
    bus.mem_rvalid = 0;
    bus.mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_rvalid = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        bus.mem_rvalid = 1;
        bus.mem_rdata = mem_data(q[0].a);
        void'(q.pop_front());
      end
    end
  end

  // reference model: the PC only moves on accepted redirects or transfers, and whatever is presented
  // must be the memory word at that PC
  always @(negedge clk) begin
    bit acc, rej, xfer;
    if (reset) begin
      chk("rst_pc", bus.pc_current, RST_PC);
      chk("rst_valid", {31'b0, bus.instr_valid}, 0);
      chk("rst_req", {31'b0, bus.mem_req}, 0);
      chk("rst_instr", bus.instr, 32'h0000_0013);
      chk("rst_mis", {31'b0, bus.misalign_err}, 0);
      exp_pc = RST_PC;
      idle = 1;
      exp_mis = 0;
      hold = 0;
    end else begin
      chk("pc", bus.pc_current, exp_pc);
      chk("misalign", {31'b0, bus.misalign_err}, {31'b0, exp_mis});
      if (idle) begin
        chk("idle_req", {31'b0, bus.mem_req}, 0);
        chk("idle_valid", {31'b0, bus.instr_valid}, 0);
      end
      if (bus.mem_req) chk("req_addr", bus.mem_addr, exp_pc);
      if (bus.instr_valid) begin
        chk("out_no_req", {31'b0, bus.mem_req}, 0);
        chk("instr", bus.instr, mem_data(exp_pc));
      end
      if (hold) chk("hold_valid", {31'b0, bus.instr_valid}, 1);
      acc = !idle && bus.jump;
      rej = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      rej = acc && (bus.pc_imm[1:0] != 2'b00);
      acc = acc && !rej;
`endif
      xfer = bus.instr_valid && bus.instr_ready;
      hold = bus.instr_valid && !bus.instr_ready && !acc;
      exp_pc = acc ? (bus.pc_imm & 32'hFFFF_FFFC) : xfer ? exp_pc + 32'd4 : exp_pc;
      exp_mis = rej;
      idle = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc[$];
    logic [31:0] ra[$];
    int vc[$];
    int nreq;
    bus.jump = 0;
    bus.pc_imm = 0;
    bus.instr_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    // throughput after reset release
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.mem_req) begin rc.push_back(k); ra.push_back(bus.mem_addr); end
      if (bus.instr_valid) vc.push_back(k);
    end
    chk("tp_req_count", rc.size(), 3);
    chk("tp_valid_count", vc.size(), 2);
    if (rc.size() == 3) begin
      chk("tp_req0_cyc", rc[0], 1); chk("tp_req1_cyc", rc[1], 4); chk("tp_req2_cyc", rc[2], 7);
      chk("tp_addr0", ra[0], 32'h0); chk("tp_addr1", ra[1], 32'h4); chk("tp_addr2", ra[2], 32'h8);
    end
    if (vc.size() == 2) begin
      chk("tp_valid0_cyc", vc[0], 3); chk("tp_valid1_cyc", vc[1], 6);
    end
    // decode stall for 5 cycles in OUT
    step();
    bus.instr_ready = 0;
    wait_sig(0, "hold_wait");
    chk("hold_pc", bus.pc_current, 32'h8);
    chk("hold_instr", bus.instr, 32'h1234_0008);
    nreq = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nreq += int'(bus.mem_req);
    end
    chk("hold_no_req", nreq, 0);
    chk("hold_still_valid", {31'b0, bus.instr_valid}, 1);
    // redirect together with a transfer
    step();
    bus.instr_ready = 1;
    bus.jump = 1;
    bus.pc_imm = 32'h200;
    step();
    bus.jump = 0;
    wait_sig(1, "jx_wait");
    chk("jx_addr", bus.mem_addr, 32'h200);
    step();
    lat = 3;
    wait_sig(1, "seq_wait");
    chk("seq_addr", bus.mem_addr, 32'h204);
    // redirect while waiting: the in-flight response must be dropped
    step();
    bus.jump = 1;
    bus.pc_imm = 32'h100;
    step();
    bus.jump = 0;
    bus.instr_ready = 0;
    wait_sig(1, "drop_wait");
    chk("drop_addr", bus.mem_addr, 32'h100);
    wait_sig(0, "drop_valid_wait");
    chk("drop_instr", bus.instr, 32'h1234_0100);
    // PC wrap
    step();
    lat = 1;
    bus.jump = 1;
    bus.pc_imm = 32'hFFFF_FFFC;
    step();
    bus.jump = 0;
    wait_sig(0, "wrap_valid_wait");
    chk("wrap_pc", bus.pc_current, 32'hFFFF_FFFC);
    chk("wrap_instr", bus.instr, 32'h1233_FFFC);
    step();
    bus.instr_ready = 1;
    wait_sig(1, "wrap_wait");
    chk("wrap_addr", bus.mem_addr, 32'h0);
    // misaligned redirect
    step();
    bus.instr_ready = 0;
    wait_sig(0, "mis_valid_wait");
    step();
    bus.jump = 1;
    bus.pc_imm = 32'h102;
    step();
    bus.jump = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    chk("mis_pulse", {31'b0, bus.misalign_err}, 1);
    chk("mis_pc", bus.pc_current, 32'h0);
    @(negedge clk);
    chk("mis_clear", {31'b0, bus.misalign_err}, 0);
`else
    wait_sig(1, "mis_wait");
    chk("mis_addr", bus.mem_addr, 32'h100);
    chk("mis_tied", {31'b0, bus.misalign_err}, 0);
`endif
    // reset during WAIT; the late response must be ignored, and a jump in IDLE too
    step();
    lat = 3;
    bus.instr_ready = 1;
    wait_sig(1, "rw_wait");
    step();
    reset = 1;
    step();
    reset = 0;
    bus.jump = 1;
    bus.pc_imm = 32'h300;
    step();
    bus.jump = 0;
    wait_sig(0, "rw_valid_wait");
    chk("rw_pc", bus.pc_current, RST_PC);
    chk("rw_instr", bus.instr, 32'h1234_0000);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 jump  input  1  redirect request; PC takes pc_imm.
REQ-005 pc_imm  input  32  redirect target.
REQ-006 mem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-007 mem_addr  output  32  read address, equal to pc_current while mem_req=1.
REQ-008 mem_rvalid  input  1  read data valid, one cycle, at least 1 cycle after mem_req.
REQ-009 mem_rdata  input  32  read data, sampled when mem_rvalid=1.
REQ-010 instr  output  32  fetched instruction to decode.
REQ-011 instr_valid  output  1  instr holds a valid instruction.
REQ-012 instr_ready  input  1  decode accepts instr; transfer when instr_valid&instr_ready.
REQ-013 pc_current  output  32  address of the instruction being fetched or presented.
REQ-014 misalign_err  output  1  one-cycle pulse on a misaligned redirect.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, OUT; IDLE->REQ unconditionally on the first edge after reset.
REQ-016 REQ: mem_req=1, mem_addr=pc_current; next state WAIT.
REQ-017 WAIT: on mem_rvalid, instr<=mem_rdata, instr_valid<=1, next OUT; otherwise stay in WAIT with no timeout.
REQ-018 OUT: instr and instr_valid stay stable until the transfer; on transfer, pc_current<=pc_current+4, instr_valid<=0, next REQ.
REQ-019 Throughput: 1 instruction per 3 cycles with 1-cycle memory latency and instr_ready held at 1.
REQ-020 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-021 Accepted jump in any state except IDLE: pc_current<=pc_imm, instr_valid<=0, next REQ.
REQ-022 jump in WAIT sets a drop flag; the next mem_rvalid is discarded and does not load instr.
REQ-023 drop flag clears on the discarded response; a new mem_req is not issued while the drop flag is set.
REQ-024 jump and a transfer in the same OUT cycle: jump wins; the transfer completes, but the PC becomes pc_imm, not PC+4.
REQ-025 jump in IDLE is ignored.
REQ-026 mem_rvalid outside WAIT with the drop flag clear is ignored.

Reset
REQ-027 reset=1 immediately forces: state IDLE, pc_current=RESET_PC, instr=32'h0000_0013, instr_valid=0, mem_req=0, misalign_err=0, drop flag=0.
REQ-028 Reset during WAIT abandons the in-flight read; its late mem_rvalid is ignored via REQ-026.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN.
REQ-030 Defined: jump with pc_imm[1:0]!=0 is rejected; the PC and state are unchanged, and misalign_err pulses for 1 cycle.
REQ-031 Undefined: pc_imm[1:0] is forced to 2'b00 on redirect, and misalign_err is tied to 0.

Structure
REQ-032 Shared package fetch_pkg holds the FSM state encoding, the RESET_PC default, and the NOP constant 32'h0000_0013.
REQ-033 One sub-module, pc_next_calc, is combinational and selects the next PC from hold, PC+4, or the redirect target (including the alignment logic).
REQ-034 Everything else is in fetch_ctrl.

Verification
REQ-035 Reset release, 1-cycle memory latency, instr_ready=1: mem_addr sequence 0x0, 0x4, 0x8, with instr_valid every 3rd cycle.
REQ-036 Hold instr_ready=0 for 5 cycles in OUT: instr and pc_current stay stable, and no mem_req is issued.
REQ-037 jump pc_imm=0x100 during WAIT: the pending response is discarded, the next mem_addr is 0x100, and instr is never loaded with the old data.
REQ-038 jump pc_imm=0x200 together with a transfer in OUT: the next mem_addr is 0x200, not PC+4.
REQ-039 pc_current=0xFFFF_FFFC, then a transfer: the next mem_addr is 0x0.
REQ-040 pc_imm=0x102 with the macro defined: misalign_err=1 for 1 cycle and the PC is unchanged; with the macro undefined: the next mem_addr is 0x100.
